// File: rtl/scoreboard_hazard_if.sv
// scoreboard_hazard_if: decode-stage bundle between ID and the hazard scoreboard.
// master = ID stage (drives the instruction fields), slave = scoreboard (drives the controls).
//   id_valid_i, rs1_i, rs1_used_i, rs2_i, rs2_used_i : decode instruction and its source reads
//   rd_i, regwrite_i, lat_i, flush_i                  : destination, producer latency, squash
//   stall_o, pc_write_o, nop_o                        : IF_ID hold, PC enable, ID_EX bubble
//   busy_o, stall_cycles_o                            : pending-register map, stall counter
interface scoreboard_hazard_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int LAT_W    = 3,
  parameter int CNT_W    = 16
);
  logic                id_valid_i;
  logic [ADDR_W-1:0]   rs1_i;
  logic                rs1_used_i;
  logic [ADDR_W-1:0]   rs2_i;
  logic                rs2_used_i;
  logic [ADDR_W-1:0]   rd_i;
  logic                regwrite_i;
  logic [LAT_W-1:0]    lat_i;
  logic                flush_i;
  logic                stall_o;
  logic                pc_write_o;
  logic                nop_o;
  logic [NUM_REGS-1:0] busy_o;
  logic [CNT_W-1:0]    stall_cycles_o;

  modport master (
    output id_valid_i,
    output rs1_i,
    output rs1_used_i,
    output rs2_i,
    output rs2_used_i,
    output rd_i,
    output regwrite_i,
    output lat_i,
    output flush_i,
    input  stall_o,
    input  pc_write_o,
    input  nop_o,
    input  busy_o,
    input  stall_cycles_o
  );

  modport slave (
    input  id_valid_i,
    input  rs1_i,
    input  rs1_used_i,
    input  rs2_i,
    input  rs2_used_i,
    input  rd_i,
    input  regwrite_i,
    input  lat_i,
    input  flush_i,
    output stall_o,
    output pc_write_o,
    output nop_o,
    output busy_o,
    output stall_cycles_o
  );
endinterface

// File: rtl/scoreboard_hazard.sv
// scoreboard_hazard: per-register latency countdown; stalls decode on RAW/WAW hazards.
// Ports: clk_i, rst_i (async, active-low), sb (slave side of scoreboard_hazard_if).
// Outputs via sb: stall_o, pc_write_o, nop_o (combinational), busy_o, stall_cycles_o.
module scoreboard_hazard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int LAT_W    = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  scoreboard_hazard_if.slave  sb
);

  logic [LAT_W-1:0] cnt_q [1:NUM_REGS-1];
  logic [LAT_W-1:0] cnt_d [1:NUM_REGS-1];

  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;

  logic [LAT_W-1:0] rs1_cnt;
  logic [LAT_W-1:0] rs2_cnt;
  logic [LAT_W-1:0] rd_cnt;
  logic [LAT_W-1:0] ld;

  logic raw;
  logic waw;
  logic stall;
  logic issue;
  logic wr_en;

  // Read ports: x0 and out-of-range indices match no entry and read 0.
  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    rd_cnt  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (sb.rs1_i == ADDR_W'(r)) begin
        rs1_cnt = cnt_q[r];
      end
      if (sb.rs2_i == ADDR_W'(r)) begin
        rs2_cnt = cnt_q[r];
      end
      if (sb.rd_i == ADDR_W'(r)) begin
        rd_cnt = cnt_q[r];
      end
    end
  end

  // Countdown starts at lat-1: the edge that issues the producer is
  // already the first cycle of its latency.
  always_comb begin
    ld = '0;
    if (sb.lat_i != '0) begin
      ld = sb.lat_i - LAT_W'(1);
    end
  end

  always_comb begin
    raw = sb.id_valid_i
        & ((sb.rs1_used_i & (rs1_cnt != '0))
        |  (sb.rs2_used_i & (rs2_cnt != '0)));
    // An older longer write must not land after this one.
    waw = sb.id_valid_i
        & sb.regwrite_i
        & (sb.rd_i != '0)
        & (rd_cnt > ld);
    stall = (raw | waw) & ~sb.flush_i;
    issue = sb.id_valid_i & ~stall & ~sb.flush_i;
    wr_en = issue & sb.regwrite_i;
  end

  // Load beats decrement; decrement runs whether or not decode stalls.
  always_comb begin
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (wr_en && (sb.rd_i == ADDR_W'(r))) begin
        cnt_d[r] = ld;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    sb.busy_o = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      sb.busy_o[r] = (cnt_q[r] != '0);
    end
  end

  assign sb.stall_o        = stall;
  assign sb.pc_write_o     = ~stall;
  assign sb.nop_o          = stall | sb.flush_i;
  assign sb.stall_cycles_o = stall_cycles_q;

endmodule
